// File: rtl/debounce_pkg.sv
// Shared definitions for pin-input conditioning blocks: debounce FSM state
// encodings and clock-related constants.
package debounce_pkg;

    // System clock driving the input blocks.
    localparam int CLK_FREQ_HZ = 12_000_000;

    // 20 ms of stability at CLK_FREQ_HZ.
    localparam int DEFAULT_STABLE_CYCLES = 240_000;

    // Encoding keeps bit 1 equal to the accepted level while idle.
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } db_state_t;

    // Converts a debounce time in milliseconds into clock cycles.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous pin. RST_VAL is the level the
// flops hold in reset, normally the pin's idle level so release is quiet.
module sincronizador_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the pin through two flops to settle metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/boton_antirrebote.sv
// Push-button debouncer: synchronizes the raw pin, requires STABLE_CYCLES
// consecutive samples of a new level before accepting it, and emits the
// clean level w plus one-cycle rise/fall strobes, all straight from flops.
module boton_antirrebote
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic w,
    output logic w_rise,
    output logic w_fall
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    db_state_t     state;
    logic [CW-1:0] cnt;
    logic          sync_q;
    logic          s;

    // Flops reset to the released pin level so leaving reset never looks
    // like a press.
    sincronizador_2ff #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (sync_q)
    );

    // Normalize to 1 = pressed.
    assign s = BTN_ACTIVE_LOW ? ~sync_q : sync_q;

    // Debounce FSM: any disagreement during a wait falls back to the idle
    // state, so the count always restarts from zero on a bounce.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            w      <= 1'b0;
            w_rise <= 1'b0;
            w_fall <= 1'b0;
        end else begin
            w_rise <= 1'b0;
            w_fall <= 1'b0;
            unique case (state)
                IDLE_LOW: begin
                    cnt <= '0;
                    if (s) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE_HIGH;
                        cnt    <= '0;
                        w      <= 1'b1;
                        w_rise <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    cnt <= '0;
                    if (!s) state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (s) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= IDLE_LOW;
                        cnt    <= '0;
                        w      <= 1'b0;
                        w_fall <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boton_antirrebote.sv
// Randomized bench for boton_antirrebote with a scoreboard. The reference
// model works from the timing rules: the pressed level seen at edge e is the
// pin sampled at edge e-2, and w flips once that level has disagreed with w
// for STABLE_CYCLES+1 consecutive edges.
module tb_boton_antirrebote;

    localparam int S = 4;

    logic clk = 1'b0;
    logic reset;
    logic btn_raw;
    logic w, w_rise, w_fall;

    boton_antirrebote #(
        .STABLE_CYCLES  (S),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .w       (w),
        .w_rise  (w_rise),
        .w_fall  (w_fall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];   // {w, w_rise, w_fall} expected after each edge
    int model_rises = 0, model_falls = 0;
    int dut_rises = 0, dut_falls = 0;

    // Reference model state.
    logic raw_d1 = 1'b1, raw_d2 = 1'b1;  // pin samples one and two edges ago
    logic mw = 1'b0;
    int   run = 0;

    // Model: advance at each active edge, push the expected outputs.
    always @(posedge clk) begin
        logic pressed, r, f;
        r = 1'b0;
        f = 1'b0;
        if (!reset) begin
            raw_d1 = 1'b1;
            raw_d2 = 1'b1;
            mw     = 1'b0;
            run    = 0;
        end else begin
            pressed = ~raw_d2;
            raw_d2  = raw_d1;
            raw_d1  = btn_raw;
            if (pressed != mw) begin
                run = run + 1;
                if (run == S + 1) begin
                    mw  = pressed;
                    run = 0;
                    r   = pressed;
                    f   = ~pressed;
                end
            end else begin
                run = 0;
            end
        end
        if (r) model_rises++;
        if (f) model_falls++;
        exp_q.push_back({mw, r, f});
    end

    // Monitor: compare DUT outputs away from the active edge.
    always @(negedge clk) begin
        logic [2:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({w, w_rise, w_fall} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got w/rise/fall=%b%b%b want %b",
                         $time, w, w_rise, w_fall, e);
            end
            checks++;
            if ((w_rise & w_fall) !== 1'b0) begin
                errors++;
                $display("FAIL strobe_overlap t=%0t rise=%b fall=%b want not both",
                         $time, w_rise, w_fall);
            end
            if (w_rise === 1'b1) dut_rises++;
            if (w_fall === 1'b1) dut_falls++;
        end
    end

    task automatic drive(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            btn_raw = lvl;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Released after reset: nothing happens.
        drive(1'b1, 8);
        // Clean press then clean release.
        drive(1'b0, 12);
        drive(1'b1, 12);
        // Glitch of 3 cycles.
        drive(1'b0, 3);
        drive(1'b1, 10);
        // Bounce pattern, then held.
        drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 2); drive(1'b1, 1);
        drive(1'b0, 12);
        // Release with a bounce.
        drive(1'b1, 2); drive(1'b0, 1); drive(1'b1, 12);
        // Reset mid-wait at cnt=2, button held across release.
        drive(1'b0, 5);
        do_reset(2);
        drive(1'b0, 12);
        drive(1'b1, 12);

        // Random segments with occasional resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0)
                do_reset($urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0)
                drive(1'(~btn_raw), $urandom_range(S + 3, S + 10));
            else
                drive(1'($urandom_range(0, 1)), $urandom_range(1, S + 1));
        end
        drive(1'b1, 12);
        repeat (2) @(negedge clk);

        checks++;
        if (dut_rises != model_rises || model_rises == 0) begin
            errors++;
            $display("FAIL rise_count got %0d want %0d (nonzero)", dut_rises, model_rises);
        end
        checks++;
        if (dut_falls != model_falls || model_falls == 0) begin
            errors++;
            $display("FAIL fall_count got %0d want %0d (nonzero)", dut_falls, model_falls);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/boton_antirrebote.md
# boton_antirrebote

Synchronizes and debounces a raw push-button input and produces the clean one-bit level `w` consumed by the Mealy sequence detector directly downstream. It also emits one-cycle rise/fall strobes for counters or LEDs. Sits between the FPGA pin and the detector, in the detector's clock domain.

## Interface

- `STABLE_CYCLES`, default 240000 (20 ms at 12 MHz): consecutive stable cycles required to accept a new level; legal range ≥ 2.
- `BTN_ACTIVE_LOW`, default 1: 1 means pin low = pressed (`w`=1).
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low: 0 = reset asserted.
- `btn_raw`  in  1  raw button pin; asynchronous and bouncy.
- `w`  out  1  debounced level, 1 = pressed; registered; drives the detector's `w`.
- `w_rise`  out  1  one-cycle pulse on the cycle `w` goes 0→1.
- `w_fall`  out  1  one-cycle pulse on the cycle `w` goes 1→0.

## Operation

- **Input conditioning.** `btn_raw` passes through a 2-FF synchronizer, then is inverted when `BTN_ACTIVE_LOW`=1. The result is the synchronized level `s`.
- **State machine.** Four states: `IDLE_LOW`, `WAIT_HIGH`, `IDLE_HIGH`, `WAIT_LOW`.
- **Counter.** Width is $clog2(`STABLE_CYCLES`). It is cleared on every state change.
- **`IDLE_LOW`** (`w`=0):
  - `s`=1 → `WAIT_HIGH`, cnt←0.
  - Otherwise stay.
- **`WAIT_HIGH`** (`w`=0):
  - `s`=0 → `IDLE_LOW`. This is a glitch: no strobe.
  - `s`=1 and cnt<`STABLE_CYCLES`−1 → cnt←cnt+1.
  - `s`=1 and cnt=`STABLE_CYCLES`−1 → `IDLE_HIGH`, `w`←1, `w_rise`←1.
- **`IDLE_HIGH` and `WAIT_LOW`** mirror the above with polarity swapped. Commit → `IDLE_LOW`, `w`←0, `w_fall`←1.
- **Strobes.** `w_rise` and `w_fall` are registered, high for exactly one cycle, and never high together. They deassert on the next edge unless a new commit occurs, which cannot happen within `STABLE_CYCLES` cycles.
- **Counter range.** The counter never wraps; it saturates logically because the transition occurs at `STABLE_CYCLES`−1.
- **Reset** (`reset`=0, asynchronous):
  - State ← `IDLE_LOW`, cnt←0.
  - `w`=0, `w_rise`=0, `w_fall`=0.
  - Synchronizer FFs are loaded with the released (not-pressed) pin level.
  - Reset asserted mid-`WAIT_*` aborts the wait with no strobe.
  - A button held through reset release is accepted after the full latency below; `w_rise` is emitted.

## Timing

- `btn_raw` is sampled at edge j; `s` reflects it after edge j+1.
- If the raw level stays constant, `w` changes after edge j+2+`STABLE_CYCLES`. The matching strobe is high during the cycle following that edge.
- A pulse on `btn_raw` shorter than `STABLE_CYCLES` cycles (after synchronization) never changes `w`.
- Any bounce during `WAIT_*` restarts the full wait from the stable state.
- All outputs are registered directly from FFs, with no combinational path from `btn_raw`. This keeps the downstream Mealy output `z` glitch-free with respect to the pin.

## Structure

- **Shared package `debounce_pkg`:**
  - 2-bit state encodings: `IDLE_LOW`=00, `WAIT_HIGH`=01, `IDLE_HIGH`=11, `WAIT_LOW`=10.
  - Default `STABLE_CYCLES` constant.
  - Clock-frequency constant (12 MHz), reused by other input blocks.
- **Sub-module `sincronizador_2ff`:** 2-flop synchronizer with a reset-value parameter. It is reused for other pin inputs.
- The FSM, counter and strobe registers live in the top module.

## Test plan

Run with `STABLE_CYCLES`=4 and `BTN_ACTIVE_LOW`=1.

- **Reset values:** `reset`=0 with `btn_raw`=1 → `w`=0, `w_rise`=0, `w_fall`=0; no strobe after release while `btn_raw` stays 1.
- **Clean press:** `btn_raw` 1→0 sampled at edge j and held → `w`=1 after edge j+6; `w_rise`=1 for exactly one cycle; `w_fall` stays 0.
- **Glitch rejection:** `btn_raw`=0 for 3 cycles, then 1 → `w` stays 0, no strobes; state returns to `IDLE_LOW`.
- **Bounce:** press pattern 0,1,0,0,1,0,0,0,0,… → `w` rises only 6 edges after the last 1→0 transition; exactly one `w_rise`.
- **Clean release:** from `w`=1, `btn_raw`→1 held → `w`=0 after 6 edges; exactly one `w_fall`.
- **Reset mid-wait:** assert `reset` during `WAIT_HIGH` at cnt=2 → `w`=0 and no `w_rise`. Button held across release → `w_rise` 6 edges after the first post-reset sampling edge.
